pico_sim_moving_average: RTL and testbench
==========================================

// Module: pico_sim_moving_average
// PURPOSE
//   Memory-to-memory moving-average engine behind the host command stream. Takes one
//   128-bit command {32'h0, len, dst, src} (src = bits[31:0], dst = [63:32], len = [95:64]).
//   Reads len bytes of 128-bit words from src and writes one 128-bit 4-tap moving average
//   per input word to dst. Sits between the host stream port and the DDR3 controller.
// PARAMETERS
//   ADDR_W   32  byte-address width of memory ports
//   FIFO_D   8   result FIFO depth; also the cap on in-flight words (reads outstanding + FIFO)
// PORTS
//   clk          in   1    system clock
//   rstn         in   1    synchronous reset, active low
//   cmd_valid    in   1    command word valid
//   cmd_rdy      out  1    command accepted when cmd_valid & cmd_rdy
//   cmd_data     in   128  {32'h0, len[31:0], dst[31:0], src[31:0]}
//   rd_valid     out  1    read request valid
//   rd_ready     in   1    read request accepted
//   rd_addr      out  32   16-byte-aligned read byte address
//   rdata_valid  in   1    read data beat (returns in request order)
//   rdata        in   128  read data
//   wr_valid     out  1    write request valid
//   wr_ready     in   1    write accepted
//   wr_addr      out  32   16-byte-aligned write byte address
//   wr_data      out  128  moving-average word
//   busy         out  1    command in progress
//   done         out  1    one-cycle pulse after the last write is accepted
// BEHAVIOUR
//   Reset (rstn=0 at clk edge): all outputs 0 except cmd_rdy=0; counters, FIFO and sum cleared.
//     Reset mid-command aborts it: no further requests, no done pulse.
//   States: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: cmd_rdy=1. On accept, latch src/dst/len; go to RUN. If len==0, go to DONE instead
//       (no memory traffic).
//     RUN: cmd_rdy=0, busy=1. Issue reads src, src+16, ... back-to-back while
//       rd_count < len/16 and (outstanding reads + FIFO occupancy) < FIFO_D.
//       Each rdata beat i computes the result and pushes it into the FIFO.
//       FIFO head drives wr_valid; wr_addr = dst + 16*k for the k-th write; pops on wr_ready.
//       When len/16 writes have been accepted, go to DONE.
//     DONE: done=1 for one cycle, busy=0; then IDLE.
//   len is in bytes; a multiple of 16 is required (the low 4 bits are ignored).
//     src and dst low 4 bits are ignored.
//   Arithmetic: sample x[i] = rdata[31:0] (upper 96 bits ignored). A 34-bit running sum is
//     kept: sum += x[i], and sum -= x[i-4] when i>3, held in a 4-entry history shift register.
//     Result y[i] = {96'b0, sum[33:2]}. For i<4 the missing samples count as 0
//     (y[0] = x[0]>>2). History and sum are cleared at each command accept.
//   Throughput: with rd_ready/wr_ready held high and fixed read latency, one read and one write
//     per cycle in steady state. Pipeline latency rdata -> wr_valid = 2 cycles.
//   Backpressure: wr_ready low stalls FIFO pops and then read issue; no data is lost or reordered.
//   Overlap: src/dst ranges are not checked; overlapping ranges give undefined results.
//   A cmd_valid while busy is held off (cmd_rdy=0) and is not dropped.
// TESTING
//   1 Load 256 random 32-bit words at 0; cmd {0,4096,4096,0} -> 256 writes at 4096..8176,
//     y[i] = (x[i]+...+x[i-3])>>2 with zero fill; done pulses once.
//   2 x = 0xFFFFFFFF for 8 words -> y = 3FFFFFFF, 7FFFFFFF, BFFFFFFF, FFFFFFFF, FFFFFFFF... (34-bit sum, no overflow).
//   3 Upper bits set, {96'hF.., 32'd8} x4 -> y = 2,4,6,8; upper result bits 0.
//   4 len=0 -> no rd_valid/wr_valid; done one cycle after accept.
//   5 wr_ready toggled randomly, read latency 1..20 cycles -> same results as 1,
//     in address order, outstanding <= 8.
//   6 rstn low mid-run (after 100 writes) -> outputs clear; a new command runs
//     correctly with the sum restarted.

Source files
------------

// File: rtl/pico_sim_moving_average.sv
// pico_sim_moving_average
//   Memory-to-memory 4-tap moving-average engine. Accepts one 128-bit command
//   {32'h0, len, dst, src}, streams len/16 words from src, and writes one averaged
//   word per input word to dst.
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   cmd_valid/cmd_rdy/cmd_data  command handshake
//   rd_valid/rd_ready/rd_addr   read request channel
//   rdata_valid/rdata           in-order read data beats
//   wr_valid/wr_ready/wr_addr/wr_data  write channel
//   busy                        command in progress
//   done                        one-cycle pulse after the final write is accepted
module pico_sim_moving_average #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned FIFO_D = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_rdy,
   input  logic [127:0]      cmd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rdata_valid,
   input  logic [127:0]      rdata,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [127:0]      wr_data,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PTR_W = $clog2(FIFO_D);
   localparam int unsigned CNT_W = $clog2(FIFO_D + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            r_state;
   state_e            w_state_nxt;

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [27:0]       r_words;
   logic [27:0]       r_rd_cnt;
   logic [27:0]       r_wr_cnt;

   // Words issued but not yet written: outstanding reads + pipeline stage + FIFO.
   logic [CNT_W-1:0]  r_inflight;
   logic [CNT_W-1:0]  r_fifo_cnt;
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [31:0]       r_fifo [FIFO_D];

   logic [31:0]       r_hist [4];
   logic [33:0]       r_sum;
   logic [31:0]       r_y;
   logic              r_y_valid;

   logic              w_cmd_fire;
   logic              w_rd_fire;
   logic              w_wr_fire;
   logic              w_beat;
   logic [33:0]       w_sum_nxt;
   logic              w_unused;

   assign w_cmd_fire = cmd_valid & cmd_rdy;
   assign w_rd_fire  = rd_valid & rd_ready;
   assign w_wr_fire  = wr_valid & wr_ready;
   assign w_beat     = rdata_valid & (r_state == StRun);

   // hist[3] is x[i-4]; it is zero for the first four beats since history starts cleared.
   assign w_sum_nxt  = r_sum + {2'b00, rdata[31:0]} - {2'b00, r_hist[3]};

   assign wr_valid = (r_fifo_cnt != '0);
   assign wr_data  = wr_valid ? {96'b0, r_fifo[r_rptr]} : 128'b0;
   assign wr_addr  = r_dst + ADDR_W'({r_wr_cnt, 4'b0000});
   assign rd_addr  = r_src + ADDR_W'({r_rd_cnt, 4'b0000});

   assign w_unused = ^{cmd_data[127:96], cmd_data[67:64], cmd_data[35:32], cmd_data[3:0],
                       rdata[127:32]};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_rdy     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      rd_valid    = 1'b0;
      unique case (r_state)
         StIdle: begin
            cmd_rdy = rstn;
            if (cmd_valid && rstn) begin
               w_state_nxt = (cmd_data[95:68] == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            busy     = 1'b1;
            rd_valid = (r_rd_cnt < r_words) && (r_inflight < CNT_W'(FIFO_D));
            if (w_wr_fire && (r_wr_cnt == r_words - 28'd1)) begin
               w_state_nxt = StDone;
            end
         end
         StDone: begin
            done        = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_src      <= '0;
         r_dst      <= '0;
         r_words    <= '0;
         r_rd_cnt   <= '0;
         r_wr_cnt   <= '0;
         r_inflight <= '0;
         r_fifo_cnt <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_sum      <= '0;
         r_y        <= '0;
         r_y_valid  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_hist[i] <= '0;
         end
      end else begin
         r_y_valid <= w_beat;
         if (w_cmd_fire) begin
            r_src    <= {cmd_data[ADDR_W-1:4], 4'b0000};
            r_dst    <= {cmd_data[32+ADDR_W-1:36], 4'b0000};
            r_words  <= cmd_data[95:68];
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_sum    <= '0;
            for (int i = 0; i < 4; i++) begin
               r_hist[i] <= '0;
            end
         end else begin
            if (w_rd_fire) begin
               r_rd_cnt <= r_rd_cnt + 28'd1;
            end
            if (w_wr_fire) begin
               r_wr_cnt <= r_wr_cnt + 28'd1;
            end
            if (w_beat) begin
               r_sum     <= w_sum_nxt;
               r_y       <= w_sum_nxt[33:2];
               r_hist[0] <= rdata[31:0];
               r_hist[1] <= r_hist[0];
               r_hist[2] <= r_hist[1];
               r_hist[3] <= r_hist[2];
            end
         end

         unique case ({w_rd_fire, w_wr_fire})
            2'b10:   r_inflight <= r_inflight + CNT_W'(1);
            2'b01:   r_inflight <= r_inflight - CNT_W'(1);
            default: r_inflight <= r_inflight;
         endcase

         unique case ({r_y_valid, w_wr_fire})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase

         if (r_y_valid) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_wr_fire) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (r_y_valid) begin
         r_fifo[r_wptr] <= r_y;
      end
   end

endmodule

// File: tb/tb_pico_sim_moving_average.sv
// tb_pico_sim_moving_average
//   Scoreboard bench: a window-sum reference model pushes expected writes when a command
//   is issued; a monitor pops and compares on every accepted write. A memory model
//   answers reads in order with fixed or random latency.
module tb_pico_sim_moving_average;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_rdy;
   logic [127:0] cmd_data = '0;
   logic         rd_valid;
   logic         rd_ready = 1'b0;
   logic [31:0]  rd_addr;
   logic         rdata_valid = 1'b0;
   logic [127:0] rdata = '0;
   logic         wr_valid;
   logic         wr_ready = 1'b0;
   logic [31:0]  wr_addr;
   logic [127:0] wr_data;
   logic         busy;
   logic         done;

   pico_sim_moving_average #(
      .ADDR_W(32),
      .FIFO_D(8)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cmd_valid  (cmd_valid),
      .cmd_rdy    (cmd_rdy),
      .cmd_data   (cmd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_addr    (rd_addr),
      .rdata_valid(rdata_valid),
      .rdata      (rdata),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
   } wr_t;

   typedef struct packed {
      logic [31:0]  due;
      logic [127:0] data;
   } rsp_t;

   wr_t          exp_q[$];
   rsp_t         rsp_q[$];
   logic [127:0] mem [int unsigned];

   int          total = 0;
   int          bad = 0;
   int          mode = 0;           // 0: ready high, latency 3; 1: random ready and latency
   int unsigned cyc = 0;
   int unsigned mcyc = 0;
   int unsigned done_cnt = 0;
   int unsigned done_cyc = 0;
   int unsigned wr_cnt = 0;
   int unsigned rdv_cnt = 0;
   int unsigned wrv_cnt = 0;
   int          inflight = 0;
   int          max_inflight = 0;

   function automatic logic [127:0] rd_word(input int unsigned wi);
      if (mem.exists(wi)) return mem[wi];
      return '0;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: y[k] = (x[k] + x[k-1] + x[k-2] + x[k-3]) / 4, missing samples are zero.
   task automatic expect_cmd(input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] len);
      int unsigned  n;
      int unsigned  sb;
      logic [31:0]  db;
      logic [127:0] w;
      longint unsigned s;
      wr_t          e;
      n  = len >> 4;
      sb = src >> 4;
      db = dst & 32'hFFFF_FFF0;
      for (int k = 0; k < int'(n); k++) begin
         s = 0;
         for (int j = 0; j < 4; j++) begin
            if (k >= j) begin
               w = rd_word(sb + k - j);
               s = s + longint'(w[31:0]);
            end
         end
         s = s / 4;
         e.addr = db + 32'(16 * k);
         e.data = {96'b0, s[31:0]};
         exp_q.push_back(e);
      end
   endtask

   // Memory model: in-order responses, one beat per cycle at most.
   initial begin
      logic [31:0] last_due;
      logic [31:0] due;
      rsp_t        r;
      last_due = 0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (!rstn) begin
            rsp_q.delete();
            rdata_valid = 1'b0;
            rdata       = '0;
            rd_ready    = 1'b0;
            wr_ready    = 1'b0;
            inflight    = 0;
            last_due    = cyc;
            continue;
         end
         if (mode == 0) begin
            rd_ready = 1'b1;
            wr_ready = 1'b1;
         end else begin
            rd_ready = ($urandom_range(3) != 0);
            wr_ready = ($urandom_range(1) != 0);
         end
         if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            r           = rsp_q.pop_front();
            rdata_valid = 1'b1;
            rdata       = r.data;
         end else begin
            rdata_valid = 1'b0;
            rdata       = {$urandom, $urandom, $urandom, $urandom};
         end
         if (rd_valid) rdv_cnt++;
         if (rd_valid && rd_ready) begin
            due = cyc + ((mode == 0) ? 3 : $urandom_range(20, 1));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due  = due;
            r.data = rd_word(rd_addr >> 4);
            rsp_q.push_back(r);
            inflight++;
            if (inflight > max_inflight) max_inflight = inflight;
         end
      end
   end

   // Monitor: compares every accepted write against the scoreboard.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         #2;
         mcyc++;
         if (!rstn) continue;
         if (done) begin
            done_cnt++;
            done_cyc = mcyc;
         end
         if (wr_valid) wrv_cnt++;
         if (wr_valid && wr_ready) begin
            wr_cnt++;
            inflight--;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got addr %h data %h want none", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", {96'b0, wr_addr}, {96'b0, e.addr});
               check("wr_data", wr_data, e.data);
            end
         end
      end
   end

   task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] len, output int unsigned acc);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = {32'h0, len, dst, src};
      #3;
      n = 0;
      while (!cmd_rdy && n < 1000) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (!cmd_rdy) begin
         total++;
         bad++;
         $display("FAIL cmd_accept: got cmd_rdy=0 want 1 within 1000 cycles");
      end
      acc = mcyc;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_data  = '0;
   endtask

   task automatic run_cmd(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] len, output int unsigned acc);
      int unsigned d0;
      int unsigned w0;
      int          n;
      d0 = done_cnt;
      w0 = wr_cnt;
      expect_cmd(src, dst, len);
      send_cmd(src, dst, len, acc);
      n = 0;
      while (done_cnt == d0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      #3;
      check({name, "_done_pulses"}, 128'(done_cnt - d0), 128'd1);
      check({name, "_writes"}, 128'(wr_cnt - w0), 128'(len >> 4));
      check({name, "_left_expected"}, 128'(exp_q.size()), 128'd0);
      check({name, "_idle_busy"}, {127'b0, busy}, 128'd0);
      exp_q.delete();
   endtask

   initial begin
      int unsigned acc;
      int unsigned r0;
      int unsigned v0;
      int unsigned d0;
      int unsigned w0;
      int          n;

      for (int i = 0; i < 256; i++) mem[i] = {96'b0, $urandom};
      for (int i = 0; i < 8; i++) mem[32'h1000 + i] = {96'b0, 32'hFFFF_FFFF};
      for (int i = 0; i < 4; i++) mem[32'h3000 + i] = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'd8};

      // Reset state.
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      check("rst_ctrl", {123'b0, cmd_rdy, busy, done, rd_valid, wr_valid}, 128'd0);
      check("rst_wr_data", wr_data, 128'd0);
      @(negedge clk);
      rstn = 1'b1;
      #3;
      check("idle_cmd_rdy", {127'b0, cmd_rdy}, 128'd1);

      run_cmd("t1", 32'd0, 32'd4096, 32'd4096, acc);
      run_cmd("t2", 32'h10000, 32'h20000, 32'd128, acc);
      run_cmd("t3", 32'h30000, 32'h40000, 32'd64, acc);
      // Low address and length bits are ignored.
      run_cmd("t3u", 32'h30007, 32'h50009, 32'h4F, acc);

      r0 = rdv_cnt;
      v0 = wrv_cnt;
      run_cmd("t4", 32'h0, 32'h6000, 32'd0, acc);
      check("t4_no_rd_valid", 128'(rdv_cnt - r0), 128'd0);
      check("t4_no_wr_valid", 128'(wrv_cnt - v0), 128'd0);
      check("t4_done_latency", 128'(done_cyc - acc), 128'd1);

      mode = 1;
      max_inflight = 0;
      run_cmd("t5", 32'd0, 32'd4096, 32'd4096, acc);
      check("t5_max_inflight_le8", {127'b0, (max_inflight <= 8)}, 128'd1);
      mode = 0;

      // Abort a run after 100 writes.
      w0 = wr_cnt;
      expect_cmd(32'd0, 32'h8000, 32'd4096);
      send_cmd(32'd0, 32'h8000, 32'd4096, acc);
      n = 0;
      while ((wr_cnt - w0) < 100 && n < 5000) begin
         @(negedge clk);
         #3;
         n++;
      end
      check("t6_reached_100", {127'b0, ((wr_cnt - w0) >= 100)}, 128'd1);
      @(negedge clk);
      rstn = 1'b0;
      exp_q.delete();
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      #3;
      check("t6_rst_ctrl", {123'b0, cmd_rdy, busy, done, rd_valid, wr_valid}, 128'd0);
      check("t6_rst_addr", {64'b0, rd_addr, wr_addr}, 128'd0);
      check("t6_rst_wr_data", wr_data, 128'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      #3;
      check("t6_no_done", 128'(done_cnt - d0), 128'd0);
      run_cmd("t6_new", 32'h30000, 32'h9000, 32'd64, acc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
